// File: rtl/shape_processor_sfr_pkg.sv
// Shared field layout, legal limits and state encoding for the shape processor SFR bank.
package shape_processor_sfr_pkg;

  localparam int SHAPE_LSB = 0;
  localparam int SHAPE_W   = 3;
  localparam int OP_LSB    = 4;
  localparam int OP_W      = 3;

  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_NONE   = 3'd0,
    SHAPE_LINE   = 3'd1,
    SHAPE_RECT   = 3'd2,
    SHAPE_CIRCLE = 3'd3,
    SHAPE_POLY   = 3'd4
  } shape_e;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_DRAW = 3'd1,
    OP_FILL = 3'd2
  } op_e;

  localparam logic [SHAPE_W-1:0] SHAPE_MAX = SHAPE_POLY;
  localparam logic [OP_W-1:0]    OP_MAX    = OP_FILL;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_e;

endpackage

// File: rtl/shape_processor_sfr_checker.sv
// Combinational legality check of one control word.
// With SHAPE_PROCESSOR_SFR_LOCK_EN the top bit is a lock flag instead of reserved.
module shape_processor_sfr_checker
  import shape_processor_sfr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  output logic              legal
);

  logic [DATA_W-1:0]  rsv_mask;
  logic [SHAPE_W-1:0] shape;
  logic [OP_W-1:0]    op;

  always_comb begin
    rsv_mask = '1;
    rsv_mask[SHAPE_LSB +: SHAPE_W] = '0;
    rsv_mask[OP_LSB +: OP_W] = '0;
`ifdef SHAPE_PROCESSOR_SFR_LOCK_EN
    rsv_mask[DATA_W-1] = 1'b0;
`endif
    shape = word[SHAPE_LSB +: SHAPE_W];
    op    = word[OP_LSB +: OP_W];
    legal = (shape <= SHAPE_MAX) && (op <= OP_MAX) && ((word & rsv_mask) == '0);
  end

endmodule

// File: rtl/shape_processor_sfr_bank.sv
// Shadow/active control-word bank with a one-channel-per-cycle commit copy.
// Optional lock bit enabled by SHAPE_PROCESSOR_SFR_LOCK_EN.
//
// state   | meaning
// ST_IDLE | waiting for commit; writes and reads serviced
// ST_COPY | copying shadow[k] -> active[k], k = 0..NUM_CH-1; writes rejected
module shape_processor_sfr_bank
  import shape_processor_sfr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     read,
  output logic [DATA_W-1:0]        read_data,
  input  logic                     commit,
  output logic                     busy,
  output logic                     error,
  output logic [NUM_CH*DATA_W-1:0] active_ctrl
);

  logic [NUM_CH-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0]             read_data_q, read_data_d;
  logic                          error_q, error_d;
  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             cnt_q, cnt_d;

  logic              word_legal;
  logic              addr_ok;
  logic              locked;
  logic              wr_ok;
  logic [DATA_W-1:0] act_sel;
  logic [ADDR_W-1:0] copy_ch;

  shape_processor_sfr_checker #(.DATA_W(DATA_W)) u_checker (
    .word  (write_data),
    .legal (word_legal)
  );

  assign busy        = (state_q == ST_COPY);
  assign read_data   = read_data_q;
  assign error       = error_q;
  assign active_ctrl = active_q;

  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    read_data_d = read_data_q;
    state_d     = state_q;
    cnt_d       = cnt_q;

    addr_ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_CH));
    act_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(i)) act_sel = active_q[i];
    end
`ifdef SHAPE_PROCESSOR_SFR_LOCK_EN
    locked = addr_ok & act_sel[DATA_W-1];
`else
    locked = 1'b0;
`endif

    wr_ok   = write & addr_ok & word_legal & ~busy & ~locked;
    // Single error flag merges write and read rejections into one pulse.
    error_d = (write & ~wr_ok) | (read & ~addr_ok);

    if (wr_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_W'(i)) shadow_d[i] = write_data;
      end
    end

    if (read) read_data_d = addr_ok ? act_sel : '0;

    // cnt_q counts remaining channels down; the copied channel ascends from 0.
    copy_ch = ADDR_W'(NUM_CH - 1) - cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_COPY;
          cnt_d   = ADDR_W'(NUM_CH - 1);
        end
      end
      ST_COPY: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (copy_ch == ADDR_W'(i)) active_d[i] = shadow_q[i];
        end
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - ADDR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      read_data_q <= '0;
      error_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      read_data_q <= read_data_d;
      error_q     <= error_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/shape_processor_sfr_bank.md
SHAPE_PROCESSOR_SFR_BANK -- requirements
Module: shape_processor_sfr_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of control channels (legal range 1..16).
REQ-002 SHALL have parameter DATA_W, default 32, width of each control word (legal range 16..32).
REQ-003 SHALL define localparam ADDR_W = max(1, $clog2(NUM_CH)).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port write  input  1  write strobe, one transfer per cycle.
REQ-007 SHALL have port addr  input  ADDR_W  channel index for write and read.
REQ-008 SHALL have port write_data  input  DATA_W  value for the shadow control word.
REQ-009 SHALL have port read  input  1  read strobe.
REQ-010 SHALL have port read_data  output  DATA_W  registered active control word.
REQ-011 SHALL have port commit  input  1  request copy of all shadow words to active words.
REQ-012 SHALL have port busy  output  1  high while a commit copy is in progress.
REQ-013 SHALL have port error  output  1  one-cycle pulse flagging a rejected access.
REQ-014 SHALL have port active_ctrl  output  NUM_CH*DATA_W  all active words; channel i at bits [i*DATA_W +: DATA_W].

Function
REQ-015 SHALL define the control-word fields as shape [2:0] (legal 0..4), operation [6:4] (legal 0..2), reserved bits (all other bits below bit DATA_W-1) that must be zero.
REQ-016 SHALL load a legal write with addr < NUM_CH into shadow[addr] at the next edge; the active word is unchanged.
REQ-017 SHALL reject a write with illegal shape, illegal operation, nonzero reserved bits, or addr >= NUM_CH: error=1 next cycle, no state change.
REQ-018 SHALL leave every shadow and active word stable in any cycle without an accepted write or copy step.
REQ-019 SHALL, on read, drive read_data = active[addr] one cycle later and hold it until the next read; for addr >= NUM_CH, read_data=0 and error=1.
REQ-020 SHALL return the pre-edge active value when a read and a copy step hit the same channel in the same cycle.
REQ-021 SHALL implement FSM IDLE -> COPY on commit in IDLE; COPY copies shadow[k] to active[k] for k=0..NUM_CH-1, one channel per cycle; IDLE follows after the last channel.
REQ-022 SHALL assert busy in every COPY cycle, starting the cycle after commit, for exactly NUM_CH cycles.
REQ-023 SHALL reject writes while busy (error=1, no update); reads while busy are allowed.
REQ-024 SHALL ignore commit while busy (no error, no restart).
REQ-025 SHALL accept a write in the same cycle as commit in IDLE; the written value is included in the copy.
REQ-026 SHALL produce at most one error pulse per cycle, even when a read and a write are both illegal.

Reset
REQ-027 SHALL, on rst, clear all shadow and active words, read_data, error and busy to 0 and set the FSM to IDLE, including mid-COPY.
REQ-028 SHALL give rst priority over write, read and commit in the same cycle.

Configuration
REQ-029 SHALL, with SHAPE_PROCESSOR_SFR_LOCK_EN defined, treat bit DATA_W-1 as lock: once active[i] has lock=1, further writes to channel i give error=1 and no update until rst.
REQ-030 SHALL, without SHAPE_PROCESSOR_SFR_LOCK_EN, treat bit DATA_W-1 as reserved; nonzero is illegal per REQ-017.

Structure
REQ-031 SHALL place the field offsets and widths, the shape and operation enums, the legal maxima and the FSM state enum in package shape_processor_sfr_pkg.
REQ-032 SHALL use one combinational sub-module, shape_processor_sfr_checker, that maps a control word to legal/illegal.

Verification
REQ-033 SHALL cover: rst; write addr=1 data=0x00000012; commit -> busy for 4 cycles; read addr=1 -> read_data=0x00000012, error=0.
REQ-034 SHALL cover: write data=0x00000007 (shape 7) to addr=0 -> error pulse, shadow[0] and active[0] stay 0.
REQ-035 SHALL cover: commit, then write in the 2nd busy cycle -> error=1; after IDLE, active words equal the prior shadow words.
REQ-036 SHALL cover: rst asserted in the 3rd COPY cycle -> busy=0 and all active_ctrl=0 next cycle.
REQ-037 SHALL cover: with LOCK_EN, write 0x80000001 to addr=2, commit, then write 0x00000002 -> error=1, active[2] stays 0x80000001.
REQ-038 SHALL cover: NUM_CH=3, read addr=3 -> read_data=0, error=1.
